// File: rtl/demux1to2_8bits_reg.sv
// Registered 1-to-2 operand demultiplexer for the sign calculator.
// It steers an incoming byte stream into operand slots A/B, either manually by sel or as an auto-filled pair.
module demux1to2_8bits_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             sel,
  input  logic             auto_mode,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic             y0_valid,
  output logic             y1_valid,
  input  logic             y0_ack,
  input  logic             y1_ack,
  output logic             pair_valid,
  input  logic             pair_ack,
  output logic [CNT_W-1:0] pair_count
);

  typedef enum logic [1:0] {
    FILL_A = 2'd0,
    FILL_B = 2'd1,
    PAIR   = 2'd2
  } state_t;

  state_t state, state_next;
  logic   mode_q;
  logic   wr0, wr1, clr0, clr1, release_pair, idle;

  assign pair_valid = (state == PAIR);
  assign idle       = (state == FILL_A) && !y0_valid && !y1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL_A;
    end else begin
      state <= state_next;
    end
  end

  // Manual mode pins the FSM at FILL_A so a later switch to auto always starts from slot A.
  always_comb begin
    state_next   = state;
    din_ready    = 1'b0;
    wr0          = 1'b0;
    wr1          = 1'b0;
    clr0         = 1'b0;
    clr1         = 1'b0;
    release_pair = 1'b0;
    if (!mode_q) begin
      state_next = FILL_A;
      din_ready  = sel ? !y1_valid : !y0_valid;
      wr0        = din_valid && !sel && !y0_valid;
      wr1        = din_valid &&  sel && !y1_valid;
      clr0       = y0_ack && y0_valid;
      clr1       = y1_ack && y1_valid;
    end else begin
      case (state)
        FILL_A: begin
          din_ready = !y0_valid;
          wr0       = din_valid && !y0_valid;
          if (wr0) state_next = FILL_B;
        end
        FILL_B: begin
          din_ready = !y1_valid;
          wr1       = din_valid && !y1_valid;
          if (wr1) state_next = PAIR;
        end
        PAIR: begin
          if (pair_ack) begin
            release_pair = 1'b1;
            clr0         = 1'b1;
            clr1         = 1'b1;
            state_next   = FILL_A;
          end
        end
        default: state_next = FILL_A;
      endcase
    end
  end

  // A slot is only written while empty, so write and release never collide on the same slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y0         <= '0;
      y1         <= '0;
      y0_valid   <= 1'b0;
      y1_valid   <= 1'b0;
      pair_count <= '0;
      mode_q     <= 1'b0;
    end else begin
      if (wr0) begin
        y0       <= din;
        y0_valid <= 1'b1;
      end else if (clr0) begin
        y0_valid <= 1'b0;
      end
      if (wr1) begin
        y1       <= din;
        y1_valid <= 1'b1;
      end else if (clr1) begin
        y1_valid <= 1'b0;
      end
      if (release_pair) pair_count <= pair_count + 1'b1;
      if (idle) mode_q <= auto_mode;
    end
  end

endmodule
